// File: rtl/kbd_event_queue_pkg.sv
// Shared types for the keyboard event queue: register offsets, control layout
// and the watermark clamping rule.
package kbd_event_queue_pkg;

  // Register offsets on the 4-bit bus address.
  typedef enum logic [3:0] {
    DATA    = 4'h0,
    CONTROL = 4'h1,
    STATUS  = 4'h2,
    DROPS   = 4'h3
  } kbd_queue_port_t;

  // Control register state. The watermark is kept 9 bits wide so a depth of
  // 256 can be represented; only its low byte is visible on the bus.
  typedef struct packed {
    logic [8:0] watermark;
    logic       flush;
    logic       irq_en;
    logic       enable;
  } kbd_queue_ctrl_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // A watermark of 0 would fire permanently and one above the depth could
  // never fire, so writes are pinned into 1..depth.
  function automatic logic [8:0] clamp_watermark(input logic [7:0] value,
                                                 input int unsigned depth);
    if (value == 8'd0) return 9'd1;
    if (32'(value) > depth) return 9'(depth);
    return {1'b0, value};
  endfunction

endpackage

// File: rtl/kbd_event_ring.sv
// Ring buffer of keyboard events: register-array storage, read/write pointers
// and an occupancy count. The head entry is presented combinationally.
module kbd_event_ring
  import kbd_event_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] head,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   count_next,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  // Guard against callers that do not check occupancy themselves; a push
  // into a full ring is only legal when an entry leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Occupancy after this edge; flush dominates any push/pop.
  always_comb begin
    count_next = count;
    if (flush)                  count_next = '0;
    else if (push_ok && !pop_ok) count_next = count + 1'b1;
    else if (pop_ok && !push_ok) count_next = count - 1'b1;
  end

  // Pointers and count; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Storage write; contents are not reset since count marks validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/kbd_event_queue.sv
// Bus-attached keyboard event queue: register decode, overflow/drop
// accounting and the watermark interrupt around a kbd_event_ring.
module kbd_event_queue
  import kbd_event_queue_pkg::*;
#(
  parameter int DATA_WIDTH      = 9,
  parameter int ADDR_WIDTH      = 5,
  parameter int RESET_WATERMARK = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] event_i,
  input  logic                  event_valid_i,
  input  logic                  chip_select_i,
  input  logic [3:0]            addr_i,
  input  logic                  read_enable_i,
  output logic [31:0]           read_data_o,
  input  logic [31:0]           write_data_i,
  input  logic [3:0]            write_mask_i,
  output logic                  interrupt_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  kbd_queue_port_t       port;
  kbd_queue_ctrl_t       ctrl, ctrl_next;
  logic                  overflow, overflow_next;
  logic [15:0]           drops, drops_next;
  logic                  irq_next;
  logic [31:0]           read_next;
  logic                  bus_wr, bus_rd, flush, pop, push, lost;
  logic [DATA_WIDTH-1:0] head;
  logic [ADDR_WIDTH:0]   count, count_next;
  logic                  empty, full;
  logic                  unused_bits;

  assign port   = kbd_queue_port_t'(addr_i);
  assign bus_wr = chip_select_i && (write_mask_i != 4'b0);
  assign bus_rd = chip_select_i && read_enable_i;
  assign flush  = bus_wr && (port == CONTROL) && write_mask_i[0] && write_data_i[2];
  assign pop    = bus_rd && (port == DATA) && !empty;
  // Events are gated by the pre-write enable; the flush cycle swallows them.
  assign push   = event_valid_i && ctrl.enable && !flush && (!full || pop);
  assign lost   = event_valid_i && ctrl.enable && !flush && full && !pop;

  assign unused_bits = ^{write_data_i[31:16], write_data_i[7:3], ctrl.flush};

  kbd_event_ring #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ring (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .data_in   (event_i),
    .head      (head),
    .count     (count),
    .count_next(count_next),
    .empty     (empty),
    .full      (full)
  );

  // Next control/overflow/drop state; a DROPS write clears before this
  // cycle's loss is accounted, so a coincident drop is still recorded.
  always_comb begin
    ctrl_next     = ctrl;
    overflow_next = overflow;
    drops_next    = drops;
    if (bus_wr && port == CONTROL) begin
      if (write_mask_i[0]) begin
        ctrl_next.enable = write_data_i[0];
        ctrl_next.irq_en = write_data_i[1];
      end
      if (write_mask_i[1])
        ctrl_next.watermark = clamp_watermark(write_data_i[15:8], DEPTH);
    end
    if (bus_wr && port == DROPS) begin
      overflow_next = 1'b0;
      drops_next    = '0;
    end
    if (lost) begin
      overflow_next = 1'b1;
      if (drops_next != DROP_MAX) drops_next = drops_next + 1'b1;
    end
    irq_next = ctrl_next.irq_en &&
               ((9'(count_next) >= ctrl_next.watermark) || overflow_next);
  end

  // Read mux over the pre-write state.
  always_comb begin
    read_next = '0;
    case (port)
      DATA:    if (!empty) read_next = {15'b0, 1'b1, 16'(head)};
      CONTROL: read_next = {16'b0, ctrl.watermark[7:0], 5'b0, 1'b0, ctrl.irq_en, ctrl.enable};
      STATUS:  read_next = {13'b0, overflow, full, empty, 7'b0, 9'(count)};
      DROPS:   read_next = {16'b0, drops};
      default: read_next = '0;
    endcase
  end

  // Register state, interrupt and read data; read data holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl        <= '{watermark: 9'(RESET_WATERMARK), flush: 1'b0, irq_en: 1'b1, enable: 1'b1};
      overflow    <= 1'b0;
      drops       <= '0;
      interrupt_o <= 1'b0;
      read_data_o <= '0;
    end else begin
      ctrl        <= ctrl_next;
      overflow    <= overflow_next;
      drops       <= drops_next;
      interrupt_o <= irq_next;
      if (bus_rd) read_data_o <= read_next;
    end
  end

endmodule
